// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, direction and FSM states.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic RW_LOAD  = 1'b0;
  localparam logic RW_STORE = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Maps access size and low address bits onto big-endian byte lanes.
// Lane 0 is the byte at the access address, lane 3 the byte at address + 3.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rd_bytes_i,  // lane 0 in [31:24]
  output logic [3:0]  wr_en_o,     // bit i enables lane i
  output logic [31:0] wr_bytes_o,  // lane 0 in [31:24]
  output logic [31:0] rdata_o,
  output logic        err_o
);

  always_comb begin
    wr_en_o    = 4'b0000;
    wr_bytes_o = 32'h0;
    rdata_o    = 32'h0;
    err_o      = 1'b0;
    case (size_i)
      SIZE_BYTE: begin
        wr_en_o            = 4'b0001;
        wr_bytes_o[31:24]  = wdata_i[7:0];
        rdata_o            = {24'h0, rd_bytes_i[31:24]};
      end
      SIZE_HALF: begin
        err_o              = addr_lo_i[0];
        wr_en_o            = 4'b0011;
        wr_bytes_o[31:16]  = wdata_i[15:0];
        rdata_o            = {16'h0, rd_bytes_i[31:16]};
      end
      SIZE_WORD: begin
        err_o              = |addr_lo_i;
        wr_en_o            = 4'b1111;
        wr_bytes_o         = wdata_i;
        rdata_o            = rd_bytes_i;
      end
      default: err_o = 1'b1;
    endcase
    if (err_o) begin
      wr_en_o = 4'b0000;
      rdata_o = 32'h0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked multi-cycle big-endian data memory serving the MEM stage.
// Owns the request FSM, wait-state counter and byte array; lane mapping is in mem_lane_align.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              req_valid,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [7:0] mem [Depth];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              idle;
  logic              sel_rw;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [ADDR_W-1:0] lane_addr [4];
  logic [31:0]       rd_bytes;
  logic [3:0]        wr_en;
  logic [31:0]       wr_bytes;
  logic [31:0]       lane_rdata;
  logic              lane_err;
  logic              enter_resp;

  assign idle = (state_q == StIdle);

  // In IDLE the live request feeds the lanes so a zero-wait access can respond next cycle.
  assign sel_rw    = idle ? req_rw    : rw_q;
  assign sel_size  = idle ? req_size  : size_q;
  assign sel_addr  = idle ? req_addr  : addr_q;
  assign sel_wdata = idle ? req_wdata : wdata_q;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_addr[i] = sel_addr + ADDR_W'(i);
    end
  end

  assign rd_bytes = {mem[lane_addr[0]], mem[lane_addr[1]], mem[lane_addr[2]], mem[lane_addr[3]]};

  mem_lane_align u_lane_align (
    .size_i     (sel_size),
    .addr_lo_i  (sel_addr[1:0]),
    .wdata_i    (sel_wdata),
    .rd_bytes_i (rd_bytes),
    .wr_en_o    (wr_en),
    .wr_bytes_o (wr_bytes),
    .rdata_o    (lane_rdata),
    .err_o      (lane_err)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    enter_resp  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          rw_d    = req_rw;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_STATES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    rsp_valid_d = enter_resp;
    rsp_err_d   = enter_resp & lane_err;
    rsp_rdata_d = (enter_resp && sel_rw == RW_LOAD) ? lane_rdata : 32'h0;
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      rw_q        <= RW_LOAD;
      size_q      <= SIZE_BYTE;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Stores commit on the edge leaving RESP; the array is never reset.
  always_ff @(posedge CLK) begin
    if (state_q == StResp && rw_q == RW_STORE) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_en[i]) begin
          mem[lane_addr[i]] <= wr_bytes[8*(3-i) +: 8];
        end
      end
    end
  end

  assign req_ready = idle;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign stall     = !idle || (req_valid && !req_ready);

endmodule
